// File: rtl/mips_pipe_ctrl_pkg.sv
// Shared types for the pipelined MIPS hazard/forwarding controller: forward-select
// codes, stage scoreboard records and the register-match helper.
package mips_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  // Records are sized for the widest supported specifier; narrower ports zero-extend.
  localparam int REG_ADDR_W_MAX = 8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [REG_ADDR_W_MAX-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      regwrite;
    logic      memread;
    reg_addr_t dest;
  } stage_rec_t;

  typedef struct packed {
    stage_rec_t rec;
    reg_addr_t  rs;
    reg_addr_t  rt;
    logic       uses_rs;
    logic       uses_rt;
  } ex_rec_t;

  // Register 0 is hard-wired zero, so it never produces a hazard.
  function automatic logic rec_match(input stage_rec_t s, input reg_addr_t r);
    return s.valid && s.regwrite && (s.dest == r) && (r != '0);
  endfunction

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// ID-stage hazard inputs and pipeline control outputs of mips_pipe_ctrl.
// master = pipeline datapath side, slave = the controller.
interface mips_pipe_ctrl_if #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W_DEF
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  ex_branch_taken;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  id_byp_a;
  logic                  id_byp_b;
  logic                  stall;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_regwrite, id_memread, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
           id_byp_a, id_byp_b, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_regwrite, id_memread, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
           id_byp_a, id_byp_b, stall
  );

endinterface

// File: rtl/mips_pipe_ctrl_match.sv
// EX operand forward-select encoder: EX/MEM beats MEM/WB, which beats the regfile.
module mips_hazard_match
  import mips_pkg::*;
#(
  parameter bit FWD_EN_WB = 1'b1
) (
  input  logic       ex_valid,
  input  logic       uses,
  input  reg_addr_t  src,
  input  stage_rec_t mem_rec,
  input  stage_rec_t wb_rec,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (ex_valid) begin
      if (uses && rec_match(mem_rec, src)) begin
        sel = FWD_MEM;
      end else if (FWD_EN_WB && rec_match(wb_rec, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Optional build macro MIPS_PIPE_PERF_EN adds saturating stall/flush counters.
//
// state (scoreboard) | meaning
// ex_q               | instruction in EX: dest/ctrl plus its rs/rt reads
// mem_q              | instruction in MEM: dest/ctrl
// wb_q               | instruction in WB: dest/ctrl
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter bit FWD_EN_WB  = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic clk,
  input  logic reset,
  mips_pipe_ctrl_if.slave bus
`ifdef MIPS_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  if (REG_ADDR_W < 1 || REG_ADDR_W > REG_ADDR_W_MAX || CNT_W < 1) begin : g_param_check
    $error("mips_pipe_ctrl: unsupported REG_ADDR_W or CNT_W");
  end

  ex_rec_t    ex_q;
  ex_rec_t    id_rec;
  stage_rec_t mem_q;
  stage_rec_t wb_q;

  reg_addr_t  id_rs_x;
  reg_addr_t  id_rt_x;
  reg_addr_t  id_dest_x;

  logic       flush;
  logic       load_use;
  logic       mem_hazard;
  logic       stall_c;
  logic       bubble;

  assign id_rs_x   = reg_addr_t'(bus.id_rs);
  assign id_rt_x   = reg_addr_t'(bus.id_rt);
  assign id_dest_x = reg_addr_t'(bus.id_dest);

  // Outputs are forced to their idle values while reset is held.
  assign flush = !reset && bus.ex_branch_taken && ex_q.rec.valid;

  assign load_use = bus.id_valid && ex_q.rec.memread &&
                    ((bus.id_uses_rs && rec_match(ex_q.rec, id_rs_x)) ||
                     (bus.id_uses_rt && rec_match(ex_q.rec, id_rt_x)));

  // Without the WB path, a MEM producer cannot reach an ID consumer in time.
  assign mem_hazard = !FWD_EN_WB && bus.id_valid &&
                      ((bus.id_uses_rs && rec_match(mem_q, id_rs_x)) ||
                       (bus.id_uses_rt && rec_match(mem_q, id_rt_x)));

  assign stall_c = !reset && !flush && (load_use || mem_hazard);
  assign bubble  = stall_c || flush;

  assign bus.stall       = stall_c;
  assign bus.pc_write    = !stall_c;
  assign bus.ifid_write  = !stall_c;
  assign bus.ifid_flush  = flush;
  assign bus.idex_bubble = bubble;

  assign bus.id_byp_a = FWD_EN_WB && !reset && bus.id_uses_rs && rec_match(wb_q, id_rs_x);
  assign bus.id_byp_b = FWD_EN_WB && !reset && bus.id_uses_rt && rec_match(wb_q, id_rt_x);

  mips_hazard_match #(.FWD_EN_WB(FWD_EN_WB)) u_match_a (
    .ex_valid (ex_q.rec.valid && !reset),
    .uses     (ex_q.uses_rs),
    .src      (ex_q.rs),
    .mem_rec  (mem_q),
    .wb_rec   (wb_q),
    .sel      (bus.fwd_a)
  );

  mips_hazard_match #(.FWD_EN_WB(FWD_EN_WB)) u_match_b (
    .ex_valid (ex_q.rec.valid && !reset),
    .uses     (ex_q.uses_rt),
    .src      (ex_q.rt),
    .mem_rec  (mem_q),
    .wb_rec   (wb_q),
    .sel      (bus.fwd_b)
  );

  always_comb begin
    id_rec              = '0;
    id_rec.rec.valid    = bus.id_valid && !bubble;
    id_rec.rec.regwrite = bus.id_regwrite;
    id_rec.rec.memread  = bus.id_memread;
    id_rec.rec.dest     = id_dest_x;
    id_rec.rs           = id_rs_x;
    id_rec.rt           = id_rt_x;
    id_rec.uses_rs      = bus.id_uses_rs;
    id_rec.uses_rt      = bus.id_uses_rt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= id_rec;
      mem_q <= ex_q.rec;
      wb_q  <= mem_q;
    end
  end

`ifdef MIPS_PIPE_PERF_EN
  // stall_c is already low on flush cycles, so a flush counts only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_c && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      if (flush && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Bench for mips_pipe_ctrl: two instances (WB forwarding on/off) driven alike and
// compared every cycle against an instruction-level pipeline model.
module tb_mips_pipe_ctrl;

  localparam int PCW = 4;

  logic clk;
  logic rst;
  logic       i_valid, i_urs, i_urt, i_rw, i_mr, i_br;
  logic [4:0] i_rs, i_rt, i_dest;

  int n_checks = 0;
  int n_pass   = 0;

  mips_pipe_ctrl_if #(.REG_ADDR_W(5)) bus1 ();
  mips_pipe_ctrl_if #(.REG_ADDR_W(5)) bus0 ();

`ifdef MIPS_PIPE_PERF_EN
  logic [PCW-1:0] ps1, pf1, ps0, pf0;
`endif

  mips_pipe_ctrl #(.REG_ADDR_W(5), .FWD_EN_WB(1'b1), .CNT_W(PCW)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1.slave)
`ifdef MIPS_PIPE_PERF_EN
    ,
    .perf_stall_cnt (ps1),
    .perf_flush_cnt (pf1)
`endif
  );

  mips_pipe_ctrl #(.REG_ADDR_W(5), .FWD_EN_WB(1'b0), .CNT_W(PCW)) dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0.slave)
`ifdef MIPS_PIPE_PERF_EN
    ,
    .perf_stall_cnt (ps0),
    .perf_flush_cnt (pf0)
`endif
  );

  assign bus1.id_valid = i_valid;        assign bus0.id_valid = i_valid;
  assign bus1.id_rs = i_rs;              assign bus0.id_rs = i_rs;
  assign bus1.id_rt = i_rt;              assign bus0.id_rt = i_rt;
  assign bus1.id_uses_rs = i_urs;        assign bus0.id_uses_rs = i_urs;
  assign bus1.id_uses_rt = i_urt;        assign bus0.id_uses_rt = i_urt;
  assign bus1.id_dest = i_dest;          assign bus0.id_dest = i_dest;
  assign bus1.id_regwrite = i_rw;        assign bus0.id_regwrite = i_rw;
  assign bus1.id_memread = i_mr;         assign bus0.id_memread = i_mr;
  assign bus1.ex_branch_taken = i_br;    assign bus0.ex_branch_taken = i_br;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model: p[w][0..2] = EX, MEM, WB for the build with FWD_EN_WB = w.
  typedef struct packed {
    bit v; bit rw; bit mr; bit urs; bit urt;
    int dest; int rs; int rt;
  } ins_t;

  typedef struct packed {
    bit stall; bit flush; int fa; int fb; bit ba; bit bb;
  } exp_t;

  ins_t p [2][3];
  int   m_stall [2];
  int   m_flush [2];

  function automatic bit hit(ins_t s, int r);
    return s.v && s.rw && (s.dest == r) && (r != 0);
  endfunction

  function automatic int fsel(int w, ins_t ex, int r, bit u, ins_t mem, ins_t wb);
    if (!ex.v) return 0;
    if (u && hit(mem, r)) return 2;
    if (w == 1 && hit(wb, r)) return 1;
    return 0;
  endfunction

  function automatic exp_t expect_of(int w);
    exp_t e;
    bit   ld, mh;
    ins_t ex, mem, wb;
    ex  = p[w][0];
    mem = p[w][1];
    wb  = p[w][2];
    e   = '0;
    if (rst) return e;
    e.flush = i_br && ex.v;
    ld = i_valid && ex.mr && ((i_urs && hit(ex, int'(i_rs))) || (i_urt && hit(ex, int'(i_rt))));
    mh = (w == 0) && i_valid && ((i_urs && hit(mem, int'(i_rs))) || (i_urt && hit(mem, int'(i_rt))));
    e.stall = !e.flush && (ld || mh);
    e.fa = fsel(w, ex, ex.rs, ex.urs, mem, wb);
    e.fb = fsel(w, ex, ex.rt, ex.urt, mem, wb);
    e.ba = (w == 1) && i_urs && hit(wb, int'(i_rs));
    e.bb = (w == 1) && i_urt && hit(wb, int'(i_rt));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_cfg(input int w);
    exp_t        e;
    logic [10:0] a;
    e = expect_of(w);
    if (w == 1)
      a = {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble,
           bus1.fwd_a, bus1.fwd_b, bus1.id_byp_a, bus1.id_byp_b, bus1.stall};
    else
      a = {bus0.pc_write, bus0.ifid_write, bus0.ifid_flush, bus0.idex_bubble,
           bus0.fwd_a, bus0.fwd_b, bus0.id_byp_a, bus0.id_byp_b, bus0.stall};
    chk($sformatf("w%0d_pc_write", w),    32'(a[10]),  32'(!e.stall));
    chk($sformatf("w%0d_ifid_write", w),  32'(a[9]),   32'(!e.stall));
    chk($sformatf("w%0d_ifid_flush", w),  32'(a[8]),   32'(e.flush));
    chk($sformatf("w%0d_idex_bubble", w), 32'(a[7]),   32'(e.stall || e.flush));
    chk($sformatf("w%0d_fwd_a", w),       32'(a[6:5]), 32'(e.fa));
    chk($sformatf("w%0d_fwd_b", w),       32'(a[4:3]), 32'(e.fb));
    chk($sformatf("w%0d_byp_a", w),       32'(a[2]),   32'(e.ba));
    chk($sformatf("w%0d_byp_b", w),       32'(a[1]),   32'(e.bb));
    chk($sformatf("w%0d_stall", w),       32'(a[0]),   32'(e.stall));
`ifdef MIPS_PIPE_PERF_EN
    chk($sformatf("w%0d_perf_stall", w), 32'(w == 1 ? ps1 : ps0), 32'(m_stall[w]));
    chk($sformatf("w%0d_perf_flush", w), 32'(w == 1 ? pf1 : pf0), 32'(m_flush[w]));
`endif
  endtask

  task automatic at_sample();
    @(negedge clk);
    check_cfg(1);
    check_cfg(0);
  endtask

  task automatic at_edge();
    exp_t e;
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      e = expect_of(w);
      if (rst) begin
        for (int s = 0; s < 3; s++) p[w][s] = '0;
        m_stall[w] = 0;
        m_flush[w] = 0;
      end else begin
        p[w][2] = p[w][1];
        p[w][1] = p[w][0];
        p[w][0] = '0;
        if (!(e.stall || e.flush)) begin
          p[w][0].v = i_valid;   p[w][0].rw = i_rw;    p[w][0].mr = i_mr;
          p[w][0].urs = i_urs;   p[w][0].urt = i_urt;  p[w][0].dest = int'(i_dest);
          p[w][0].rs = int'(i_rs); p[w][0].rt = int'(i_rt);
        end
        if (e.stall && m_stall[w] < (1 << PCW) - 1) m_stall[w]++;
        if (e.flush && m_flush[w] < (1 << PCW) - 1) m_flush[w]++;
      end
    end
    #1;
  endtask

  task automatic cycle();
    at_sample();
    at_edge();
  endtask

  task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input int dest, input bit rw, input bit mr);
    i_valid = v; i_rs = 5'(rs); i_urs = urs; i_rt = 5'(rt); i_urt = urt;
    i_dest = 5'(dest); i_rw = rw; i_mr = mr; i_br = 1'b0;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < 3; s++) p[w][s] = '0;
      m_stall[w] = 0;
      m_flush[w] = 0;
    end
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    cycle(); cycle();
    rst = 1'b0;
    idle(3);

    // lw $8 then add reading $8
    set_id(1, 0, 0, 0, 0, 8, 1, 1);  cycle();
    set_id(1, 8, 1, 0, 0, 9, 1, 0);
    at_sample();
    chk("lu_stall", 32'(bus1.stall), 32'd1);
    chk("lu_pc_write", 32'(bus1.pc_write), 32'd0);
    chk("lu_bubble", 32'(bus1.idex_bubble), 32'd1);
    at_edge();
    at_sample();
    chk("lu_stall_once", 32'(bus1.stall), 32'd0);
    at_edge();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    at_sample();
    chk("lu_fwd_wb", 32'(bus1.fwd_a), 32'd1);
    at_edge();
    idle(3);

    // two writers of $3 (then $0), reader in EX: MEM wins
    for (int d = 3; d >= 0; d -= 3) begin
      set_id(1, 0, 0, 0, 0, d, 1, 0); cycle();
      set_id(1, 0, 0, 0, 0, d, 1, 0); cycle();
      set_id(1, d, 1, 0, 0, 4, 1, 0); cycle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      at_sample();
      chk($sformatf("mem_prio_d%0d", d), 32'(bus1.fwd_a), (d == 3) ? 32'd2 : 32'd0);
      at_edge();
      idle(3);
    end

    // branch taken with a simultaneous load-use
    set_id(1, 0, 0, 0, 0, 8, 1, 1); cycle();
    set_id(1, 8, 1, 0, 0, 9, 1, 0);
    i_br = 1'b1;
    at_sample();
    chk("br_flush", 32'(bus1.ifid_flush), 32'd1);
    chk("br_bubble", 32'(bus1.idex_bubble), 32'd1);
    chk("br_stall", 32'(bus1.stall), 32'd0);
    chk("br_pc_write", 32'(bus1.pc_write), 32'd1);
    at_edge();
    idle(3);

    // WB bypass of $5 into an ID rt read
    set_id(1, 0, 0, 0, 0, 5, 1, 0); cycle();
    idle(1);
    set_id(1, 0, 0, 5, 1, 6, 1, 0);
    at_sample();
    chk("nowb_stall_mem", 32'(bus0.stall), 32'd1);
    at_edge();
    at_sample();
    chk("wb_byp_b", 32'(bus1.id_byp_b), 32'd1);
    chk("nowb_byp_b", 32'(bus0.id_byp_b), 32'd0);
    chk("nowb_stall_done", 32'(bus0.stall), 32'd0);
    at_edge();
    idle(3);

    // randomized traffic with occasional mid-run reset
    for (int k = 0; k < 600; k++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      i_br = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(3);

`ifdef MIPS_PIPE_PERF_EN
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      set_id(1, 0, 0, 0, 0, 8, 1, 1); cycle();
      set_id(1, 8, 1, 0, 0, 9, 1, 0); cycle();
    end
    idle(2);
    chk("perf_sat", 32'(ps1), 32'd15);
    rst = 1'b1; cycle(); rst = 1'b0;
    at_sample();
    chk("perf_clr", 32'(ps1), 32'd0);
    at_edge();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_pipe_ctrl.md
Name: mips_pipe_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined successor of the single-cycle MIPS CPU top.
- Tracks the ID/EX, EX/MEM and MEM/WB destination-register scoreboard internally.
- Generates stall, flush and operand-forwarding selects for the Fetch/Decode/Execute stage blocks.
- Parametrised in register-address width and forwarding depth.

Parameters:
- REG_ADDR_W, 5, register specifier width (register 0 is hard-wired zero).
- FWD_EN_WB, 1, 1 = forward from MEM/WB and bypass WB into ID reads; 0 = MEM forwarding only, WB hazards resolved by stall.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  ID source specifiers
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs/rt
- id_dest  in  REG_ADDR_W  ID destination after RegDest mux
- id_regwrite, id_memread  in  1  ID control bits
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_write  out  1  PC enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  squash IF/ID
- idex_bubble  out  1  load a NOP into ID/EX
- fwd_a, fwd_b  out  2  EX operand select: 00 = regfile, 01 = MEM/WB, 10 = EX/MEM
- id_byp_a, id_byp_b  out  1  ID read takes the WB write data
- stall  out  1  load-use (or WB) hazard this cycle

Behaviour:
- State: three stage records {valid, dest, regwrite, memread} for EX, MEM and WB; EX record also holds rs, rt, uses_rs, uses_rt.
- All outputs are combinational from inputs and state. State advances on every clk: EX <- ID (or bubble), MEM <- EX, WB <- MEM.
- Reset: all valids = 0 on the reset cycle. Outputs during and after reset: stall 0, ifid_flush 0, idex_bubble 0, pc_write 1, ifid_write 1, fwd 00, byp 0.
- match(stage, r): stage.valid & stage.regwrite & stage.dest == r & r != 0. Register 0 never forwards, bypasses or stalls.
- Load-use stall: id_valid & EX.memread & (id_uses_rs & match(EX, id_rs) | id_uses_rt & match(EX, id_rt)).
- With FWD_EN_WB = 0, stall also asserts on the same condition against MEM, for any regwrite.
- Flush: ex_branch_taken & EX.valid. Drives ifid_flush = 1 and idex_bubble = 1.
- Flush beats stall: when flush is true, stall is forced 0 and pc_write = 1.
- On stall: pc_write = 0, ifid_write = 0, idex_bubble = 1. The EX record becomes a bubble next cycle; ID holds.
- idex_bubble = stall | flush. A bubble clears EX.valid.
- fwd_a: 10 if match(MEM, EX.rs) & EX.uses_rs; else 01 if FWD_EN_WB & match(WB, EX.rs); else 00. MEM has priority over WB. fwd_b is the same using rt.
- fwd outputs are 00 whenever EX.valid = 0.
- id_byp_a = FWD_EN_WB & id_uses_rs & match(WB, id_rs); id_byp_b likewise using rt. This covers the same-cycle regfile write/read case.
- Latency: hazard detection is 0 cycles. A load-use stall is exactly 1 cycle; the instruction re-evaluates the next cycle and forwards from MEM/WB.
- Reset asserted mid-operation discards all in-flight records; no stall or flush persists past reset.

Optional Feature:
- Macro: MIPS_PIPE_PERF_EN.
- Defined: adds outputs perf_stall_cnt and perf_flush_cnt (CNT_W each).
  - Each counter increments by 1 on every cycle its condition is true; a flush cycle counts as flush only.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg: fwd-select constants (FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10), the stage-record struct typedef, and REG_ADDR_W default.
- Natural sub-module: mips_hazard_match, a combinational match/priority encoder instanced for fwd_a and fwd_b.

Test Plan:
- Reset held 2 cycles, then released with id_valid = 0 -> pc_write 1, stall 0, fwd 00 and byp 0 on every cycle.
- lw $8 in EX, ID add rs = 8 (uses_rs) -> stall 1, idex_bubble 1, pc_write 0 for 1 cycle; next cycle fwd_a = 01 with WB holding $8.
- add $3 in MEM and add $3 in WB, EX reads rs = 3 -> fwd_a = 10 (MEM priority); same with dest 0 -> fwd_a = 00.
- ex_branch_taken = 1 with a simultaneous load-use condition -> ifid_flush 1, idex_bubble 1, stall 0, pc_write 1.
- WB writes $5, ID reads rt = 5 -> id_byp_b 1. With FWD_EN_WB = 0 -> id_byp_b 0, stall asserts until the record retires.
- MIPS_PIPE_PERF_EN defined, CNT_W = 4, 20 stall cycles -> perf_stall_cnt saturates at 15; reset clears it to 0.
